// File: rtl/hwpe_stream_tcdm_load_issuer_pkg.sv
// rtl/hwpe_stream_tcdm_load_issuer_pkg.sv - shared types for the TCDM load issuer
// Purpose: status flag record exported by the load issuer.
// Contents: TCDM_LOAD_FIFO_DEPTH (default response buffer depth),
//           TCDM_LOAD_OCC_WIDTH (occupancy counter width),
//           flags_tcdm_load_issuer_t {idle, inflight, fifo_occ}.
package hwpe_stream_package;

  localparam int TCDM_LOAD_FIFO_DEPTH = 4;
  localparam int TCDM_LOAD_OCC_WIDTH  = $clog2(TCDM_LOAD_FIFO_DEPTH + 1);

  typedef struct packed {
    logic                           idle;
    logic                           inflight;
    logic [TCDM_LOAD_OCC_WIDTH-1:0] fifo_occ;
  } flags_tcdm_load_issuer_t;

endpackage

// File: rtl/hwpe_stream_tcdm_load_issuer_if.sv
// rtl/hwpe_stream_tcdm_load_issuer_if.sv - stream and TCDM bus interfaces
// Purpose: bundles the handshake signals used by the load issuer.
// hwpe_stream_intf_stream: valid/ready handshake, data, strb (DATA_WIDTH/8).
//   master drives valid/data/strb, slave drives ready.
// hwpe_stream_intf_tcdm: req/gnt request channel, add/wen/be/data payload,
//   r_data/r_valid response channel. master issues requests, slave answers.
interface hwpe_stream_intf_stream #(
  parameter int DATA_WIDTH = 32
);
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport master (output valid, output data, output strb, input ready);
  modport slave  (input valid, input data, input strb, output ready);
endinterface

interface hwpe_stream_intf_tcdm #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    req;
  logic                    gnt;
  logic [ADDR_WIDTH-1:0]   add;
  logic                    wen;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_valid;

  modport master (output req, output add, output wen, output be, output data,
                  input gnt, input r_data, input r_valid);
  modport slave  (input req, input add, input wen, input be, input data,
                  output gnt, output r_data, output r_valid);
endinterface

// File: rtl/hwpe_stream_tcdm_load_issuer_fifo.sv
// rtl/hwpe_stream_tcdm_load_issuer_fifo.sv - synchronous response buffer
// Purpose: circular FIFO holding {strb, data} responses in arrival order.
// Ports: clk, rst (sync, active-high), flush (sync empty), push/push_data,
//        pop, head (oldest entry), not_empty, occ (entry count).
module hwpe_stream_fifo_sync #(
  parameter int DATA_WIDTH = 36,
  parameter int DEPTH      = 4,
  parameter int OCC_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  not_empty,
  output logic [OCC_WIDTH-1:0]  occ
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic                  full, do_push, do_pop;

  assign not_empty = (occ != '0);
  assign full      = (occ == OCC_WIDTH'(DEPTH));
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign do_push   = push & (~full | pop) & ~flush;
  assign do_pop    = pop & not_empty & ~flush;
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // The issuer's credit check must make this unreachable.
  overflow_check: assert property (@(posedge clk) disable iff (rst)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/hwpe_stream_tcdm_load_issuer.sv
// rtl/hwpe_stream_tcdm_load_issuer.sv - turns an address stream into TCDM reads
// Purpose: issues one TCDM read per incoming address, buffers the responses
//          and streams them out in address order.
// Ports: clk_i, rst_i (sync, active-high), enable_i (allow new requests),
//        clear_i (sync flush), addr_i (stream slave {be, address}),
//        tcdm (TCDM master), data_o (stream master, loaded words + strb),
//        flags_o (idle, inflight, fifo_occ).
module hwpe_stream_tcdm_load_issuer
  import hwpe_stream_package::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = TCDM_LOAD_FIFO_DEPTH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic                    clear_i,
  hwpe_stream_intf_stream.slave   addr_i,
  hwpe_stream_intf_tcdm.master    tcdm,
  hwpe_stream_intf_stream.master  data_o,
  output flags_tcdm_load_issuer_t flags_o
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int OCC_W    = TCDM_LOAD_OCC_WIDTH;
  localparam logic [OCC_W:0] CREDITS = (OCC_W + 1)'(FIFO_DEPTH);

  logic                         inflight_q;
  logic [BE_WIDTH-1:0]          be_q;
  logic [OCC_W-1:0]             fifo_occ;
  logic                         fifo_not_empty;
  logic [DATA_WIDTH+BE_WIDTH-1:0] fifo_head;
  logic [OCC_W:0]               used;
  logic                         credit_ok, req, grant, push, pop;
  logic                         unused_addr_strb;

  // Every buffered word plus the one in flight holds a FIFO slot, so the
  // response always has room by the time it returns.
  assign used      = {1'b0, fifo_occ} + {{OCC_W{1'b0}}, inflight_q};
  assign credit_ok = (used < CREDITS);
  assign req       = addr_i.valid & enable_i & ~clear_i & ~rst_i & credit_ok;
  assign grant     = req & tcdm.gnt;

  assign tcdm.req  = req;
  assign tcdm.add  = addr_i.data[ADDR_WIDTH-1:0];
  assign tcdm.be   = addr_i.data[ADDR_WIDTH +: BE_WIDTH];
  assign tcdm.wen  = 1'b1;
  assign tcdm.data = '0;
  assign addr_i.ready = grant;

  assign unused_addr_strb = ^addr_i.strb;

  // A response is only accepted for a grant we actually own; stray r_valid
  // after a clear or reset is ignored.
  assign push = tcdm.r_valid & inflight_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      inflight_q <= 1'b0;
      be_q       <= '0;
    end else if (grant) begin
      inflight_q <= 1'b1;
      be_q       <= tcdm.be;
    end else if (tcdm.r_valid) begin
      inflight_q <= 1'b0;
    end
  end

  hwpe_stream_fifo_sync #(
    .DATA_WIDTH (DATA_WIDTH + BE_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .OCC_WIDTH  (OCC_W)
  ) i_resp_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .flush     (clear_i),
    .push      (push),
    .push_data ({be_q, tcdm.r_data}),
    .pop       (pop),
    .head      (fifo_head),
    .not_empty (fifo_not_empty),
    .occ       (fifo_occ)
  );

  assign data_o.valid = fifo_not_empty & ~rst_i;
  assign data_o.data  = fifo_head[DATA_WIDTH-1:0];
  assign data_o.strb  = fifo_head[DATA_WIDTH +: BE_WIDTH];
  assign pop          = data_o.valid & data_o.ready;

  assign flags_o.idle     = ~inflight_q & ~fifo_not_empty & ~addr_i.valid;
  assign flags_o.inflight = inflight_q;
  assign flags_o.fifo_occ = fifo_occ;

endmodule

// File: tb/tb_hwpe_stream_tcdm_load_issuer.sv
// tb/tb_hwpe_stream_tcdm_load_issuer.sv - self-checking bench for the load issuer
// Purpose: directed vectors plus streaming, backpressure, random stall,
//          clear, enable and reset sequences against a TCDM memory model.
module tb_hwpe_stream_tcdm_load_issuer;
  import hwpe_stream_package::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic clear = 1'b0;
  flags_tcdm_load_issuer_t flags;

  hwpe_stream_intf_stream #(.DATA_WIDTH(36)) addr_if ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) data_if ();
  hwpe_stream_intf_tcdm #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) tcdm_if ();

  hwpe_stream_tcdm_load_issuer #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .FIFO_DEPTH(4)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear),
    .addr_i(addr_if), .tcdm(tcdm_if), .data_o(data_if), .flags_o(flags)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a5a, a[31:16] + 16'h1357};
  endfunction

  function automatic logic [3:0] be_of(input int i);
    logic [3:0] b;
    b = 4'(i * 5 + 3);
    return b;
  endfunction

  // TCDM slave: one-cycle response latency, plus a hook to inject stray r_valid.
  logic        model_rvalid = 1'b0;
  logic [31:0] model_rdata = '0;
  logic        inject = 1'b0;
  always @(posedge clk) begin
    model_rvalid <= tcdm_if.req & tcdm_if.gnt;
    model_rdata  <= mem_word(tcdm_if.add);
  end
  assign tcdm_if.r_valid = model_rvalid | inject;
  assign tcdm_if.r_data  = model_rdata;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int src_idx = 0, src_len = 0, n_out = 0;
  int first_addr_cyc = -1, first_out_cyc = -1, last_out_cyc = -1;
  int rdy_viol = 0, req_viol = 0;
  bit src_on = 0, rand_mode = 0;
  logic [31:0] src_base = '0;
  logic [35:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic drive_src();
    if (src_on && src_idx < src_len) begin
      addr_if.valid = 1'b1;
      addr_if.data  = {be_of(src_idx), src_base + 32'(src_idx) * 32'd4};
    end else begin
      addr_if.valid = 1'b0;
      addr_if.data  = '0;
    end
  endtask

  task automatic start_stream(input logic [31:0] base, input int len);
    src_on = 1; src_base = base; src_idx = 0; src_len = len; n_out = 0;
    first_addr_cyc = -1; first_out_cyc = -1; last_out_cyc = -1;
    drive_src();
  endtask

  task automatic stop_stream();
    src_on = 0;
    drive_src();
  endtask

  // Inputs are set at the negedge; handshakes sampled 1ns later, state advances at posedge.
  task automatic cycle();
    logic [35:0] w;
    #1;
    if (addr_if.ready !== (tcdm_if.req & tcdm_if.gnt)) rdy_viol++;
    if (!enable && tcdm_if.req) req_viol++;
    if (src_on && addr_if.valid && addr_if.ready) begin
      exp_q.push_back({be_of(src_idx), mem_word(src_base + 32'(src_idx) * 32'd4)});
      if (first_addr_cyc < 0) first_addr_cyc = cyc;
      src_idx++;
    end
    if (data_if.valid && data_if.ready) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL dout_extra: got word 0x%0h required none", data_if.data);
      end else begin
        w = exp_q.pop_front();
        check("dout_word", 64'({data_if.strb, data_if.data}), 64'(w));
      end
      n_out++;
      if (first_out_cyc < 0) first_out_cyc = cyc;
      last_out_cyc = cyc;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    drive_src();
    if (rand_mode) begin
      tcdm_if.gnt  = ($urandom_range(99) >= 30);
      data_if.ready = ($urandom_range(99) >= 20);
    end
  endtask

  task automatic run_to_done(input int budget, input string name);
    int k;
    k = 0;
    while ((src_idx < src_len || exp_q.size() != 0) && k < budget) begin
      cycle();
      k++;
    end
    if (k >= budget) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: got %0d cycles required completion", name, k);
    end
  endtask

  typedef struct {
    logic        valid, en, clr, gnt;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        e_req, e_rdy, e_idle;
  } vec_t;
  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_1000, 4'hf, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_1000, 4'hf, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_2004, 4'h1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_3008, 4'h2, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hdead_beec, 4'h3, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h8000_0010, 4'hc, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'h0, 1'b0, 1'b0, 1'b1};

    addr_if.valid = 1'b0; addr_if.data = '0; addr_if.strb = '0;
    tcdm_if.gnt = 1'b0; data_if.ready = 1'b0;

    // Reset with live traffic on the inputs.
    repeat (2) @(negedge clk);
    addr_if.valid = 1'b1; addr_if.data = {4'hf, 32'h100}; enable = 1'b1;
    tcdm_if.gnt = 1'b1; data_if.ready = 1'b1;
    #1;
    check("rst_req", 64'(tcdm_if.req), 64'd0);
    check("rst_addr_ready", 64'(addr_if.ready), 64'd0);
    check("rst_dout_valid", 64'(data_if.valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; addr_if.valid = 1'b0; tcdm_if.gnt = 1'b0;
    #1;
    check("post_rst_idle", 64'(flags.idle), 64'd1);
    check("post_rst_occ", 64'(flags.fifo_occ), 64'd0);
    check("post_rst_inflight", 64'(flags.inflight), 64'd0);

    // Combinational request path from the idle state; inputs drop before the edge.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      addr_if.valid = vecs[i].valid; enable = vecs[i].en; clear = vecs[i].clr;
      tcdm_if.gnt = vecs[i].gnt; addr_if.data = {vecs[i].be, vecs[i].addr};
      #1;
      check($sformatf("vec%0d_req", i), 64'(tcdm_if.req), 64'(vecs[i].e_req));
      check($sformatf("vec%0d_addr_ready", i), 64'(addr_if.ready), 64'(vecs[i].e_rdy));
      check($sformatf("vec%0d_idle", i), 64'(flags.idle), 64'(vecs[i].e_idle));
      check($sformatf("vec%0d_add", i), 64'(tcdm_if.add), 64'(vecs[i].addr));
      check($sformatf("vec%0d_be", i), 64'(tcdm_if.be), 64'(vecs[i].be));
      #1;
      addr_if.valid = 1'b0; tcdm_if.gnt = 1'b0; clear = 1'b0;
    end
    check("tcdm_wen", 64'(tcdm_if.wen), 64'd1);
    check("tcdm_wdata", 64'(tcdm_if.data), 64'd0);

    // Full-rate streaming, 128 words.
    @(negedge clk);
    enable = 1'b1; tcdm_if.gnt = 1'b1; data_if.ready = 1'b1; clear = 1'b0;
    start_stream(32'h0008_0000, 128);
    run_to_done(400, "stream");
    stop_stream();
    check("stream_count", 64'(n_out), 64'd128);
    check("stream_latency", 64'(first_out_cyc - first_addr_cyc), 64'd2);
    check("stream_rate", 64'(last_out_cyc - first_out_cyc), 64'd127);

    // Output backpressure: credits run out after FIFO_DEPTH grants.
    data_if.ready = 1'b0;
    start_stream(32'h0000_2000, 16);
    repeat (10) cycle();
    check("bp_grants", 64'(src_idx), 64'd4);
    check("bp_occ", 64'(flags.fifo_occ), 64'd4);
    check("bp_inflight", 64'(flags.inflight), 64'd0);
    check("bp_head_data", 64'(data_if.data), 64'(mem_word(32'h0000_2000)));
    check("bp_head_strb", 64'(data_if.strb), 64'(be_of(0)));
    #1;
    check("bp_req_low", 64'(tcdm_if.req), 64'd0);
    data_if.ready = 1'b1;
    run_to_done(200, "bp");
    stop_stream();
    check("bp_count", 64'(n_out), 64'd16);

    // Random grant and ready stalls.
    rdy_viol = 0;
    rand_mode = 1;
    start_stream(32'h0000_6000, 64);
    run_to_done(2000, "rand");
    rand_mode = 0;
    stop_stream();
    tcdm_if.gnt = 1'b1; data_if.ready = 1'b1;
    check("rand_count", 64'(n_out), 64'd64);
    check("rand_ready_rule", 64'(rdy_viol), 64'd0);

    // Clear with three buffered words and one in flight.
    data_if.ready = 1'b0;
    start_stream(32'h0000_3000, 4);
    repeat (4) cycle();
    check("clr_pre_occ", 64'(flags.fifo_occ), 64'd3);
    check("clr_pre_inflight", 64'(flags.inflight), 64'd1);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    exp_q.delete();
    #1;
    check("clr_occ", 64'(flags.fifo_occ), 64'd0);
    check("clr_inflight", 64'(flags.inflight), 64'd0);
    check("clr_dout_valid", 64'(data_if.valid), 64'd0);
    inject = 1'b1;
    cycle();
    inject = 1'b0;
    #1;
    check("clr_late_occ", 64'(flags.fifo_occ), 64'd0);
    check("clr_late_valid", 64'(data_if.valid), 64'd0);
    stop_stream();
    data_if.ready = 1'b1;
    start_stream(32'h0000_3800, 8);
    run_to_done(200, "clr_restart");
    stop_stream();
    check("clr_restart_count", 64'(n_out), 64'd8);

    // Enable dropped for five cycles mid-stream.
    start_stream(32'h0000_4000, 20);
    repeat (5) cycle();
    enable = 1'b0;
    req_viol = 0;
    repeat (5) cycle();
    check("en_req_low", 64'(req_viol), 64'd0);
    check("en_grants", 64'(src_idx), 64'd5);
    check("en_drained", 64'(n_out), 64'd5);
    enable = 1'b1;
    run_to_done(200, "en");
    stop_stream();
    check("en_count", 64'(n_out), 64'd20);

    // Reset while a request is in flight.
    start_stream(32'h0000_5000, 16);
    repeat (3) cycle();
    check("mrst_pre_inflight", 64'(flags.inflight), 64'd1);
    rst = 1'b1;
    #1;
    check("mrst_req", 64'(tcdm_if.req), 64'd0);
    check("mrst_addr_ready", 64'(addr_if.ready), 64'd0);
    check("mrst_dout_valid", 64'(data_if.valid), 64'd0);
    cycle();
    rst = 1'b0;
    stop_stream();
    exp_q.delete();
    inject = 1'b1;
    #1;
    check("mrst_occ", 64'(flags.fifo_occ), 64'd0);
    check("mrst_inflight", 64'(flags.inflight), 64'd0);
    check("mrst_idle", 64'(flags.idle), 64'd1);
    cycle();
    inject = 1'b0;
    #1;
    check("mrst_late_occ", 64'(flags.fifo_occ), 64'd0);
    check("mrst_late_valid", 64'(data_if.valid), 64'd0);
    check("mrst_late_idle", 64'(flags.idle), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got time limit required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
